// File: rtl/reg_cpu_arb.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// reg_cpu_arb
// Round-robin arbiter that lets NUM_MST reg_cpu masters (CPU, DMA, debug...)
// share one downstream reg_cpu slave port. It serves one transaction at a
// time, routes the slave response back to the winning master, and adds a
// per-transaction timeout plus an error flag that the bare bus lacks.
//
// Ports
//   reg_cpu_clk, rst_n    clock (posedge) and async active-low reset
//   m_cs/m_we/m_re        per-master request and qualifiers, held until response
//   m_addr/m_data_wr      packed per-master address / write data (master i at [i*W +: W])
//   m_data_rd             read data, non-zero only alongside an m_rdv pulse
//   m_wack/m_rdv/m_err    per-master 1-cycle response pulses and error flag
//   s_cs/s_we/s_re        downstream request
//   s_addr/s_data_wr      downstream address / write data
//   s_data_rd/s_wack/s_rdv downstream read data and response pulses
//   grant_id              current / last granted master
//   busy                  high while a transaction is in BUSY or DONE
// ---------------------------------------------------------------------------
module reg_cpu_arb #(
  parameter int              NUM_MST     = 4,
  parameter int              AW          = 32,
  parameter int              DW          = 32,
  parameter int              TIMEOUT_CYC = 256,
  parameter logic [DW-1:0]   ERR_DATA    = 32'hDEADBEEF
) (
  input  logic                       reg_cpu_clk,
  input  logic                       rst_n,
  input  logic [NUM_MST-1:0]         m_cs,
  input  logic [NUM_MST*AW-1:0]      m_addr,
  input  logic [NUM_MST*DW-1:0]      m_data_wr,
  input  logic [NUM_MST-1:0]         m_we,
  input  logic [NUM_MST-1:0]         m_re,
  output logic [DW-1:0]              m_data_rd,
  output logic [NUM_MST-1:0]         m_wack,
  output logic [NUM_MST-1:0]         m_rdv,
  output logic [NUM_MST-1:0]         m_err,
  output logic                       s_cs,
  output logic                       s_we,
  output logic                       s_re,
  output logic [AW-1:0]              s_addr,
  output logic [DW-1:0]              s_data_wr,
  input  logic [DW-1:0]              s_data_rd,
  input  logic                       s_wack,
  input  logic                       s_rdv,
  output logic [$clog2(NUM_MST)-1:0] grant_id,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_MST);
  // Counter only needs to reach TIMEOUT_CYC-1; the terminal compare happens there.
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TO_M1 = (TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0;
  localparam logic [CW-1:0] TO_LAST = TO_M1[CW-1:0];
  localparam logic [IW-1:0] RR_RST  = IW'(NUM_MST - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [IW-1:0]     rr_r;
  logic [CW-1:0]     cnt_r;
  logic [NUM_MST-1:0] valid_s;
  logic [IW-1:0]     win_s;
  logic              any_s;
  logic              resp_s;
  logic              tmo_s;
  int                idx_v;

  assign valid_s = m_cs & (m_we | m_re);

  // Round-robin search starting just after the last winner, with wrap.
  always_comb begin
    win_s = '0;
    any_s = 1'b0;
    idx_v = 0;
    for (int k = 1; k <= NUM_MST; k++) begin
      idx_v = (int'(rr_r) + k) % NUM_MST;
      if (!any_s && valid_s[idx_v]) begin
        any_s = 1'b1;
        win_s = IW'(idx_v);
      end else begin
        any_s = any_s;
      end
    end
  end

  // Only a response matching the outstanding access type completes it.
  assign resp_s = (s_we && s_wack) || (s_re && s_rdv);
  assign tmo_s  = (TIMEOUT_CYC != 0) && (cnt_r == TO_LAST);

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      rr_r      <= RR_RST;
      cnt_r     <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      s_cs      <= 1'b0;
      s_we      <= 1'b0;
      s_re      <= 1'b0;
      s_addr    <= '0;
      s_data_wr <= '0;
      m_wack    <= '0;
      m_rdv     <= '0;
      m_err     <= '0;
      m_data_rd <= '0;
    end else begin
      // Response outputs are single-cycle pulses unless set below.
      m_wack    <= '0;
      m_rdv     <= '0;
      m_err     <= '0;
      m_data_rd <= '0;
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            rr_r     <= win_s;
            grant_id <= win_s;
            busy     <= 1'b1;
            if (m_we[win_s] && m_re[win_s]) begin
              // Ambiguous request: answer with a write-ack error, no bus access.
              m_wack[win_s] <= 1'b1;
              m_err[win_s]  <= 1'b1;
              state_r       <= ST_DONE;
            end else begin
              s_cs      <= 1'b1;
              s_we      <= m_we[win_s];
              s_re      <= m_re[win_s];
              s_addr    <= m_addr[win_s*AW +: AW];
              s_data_wr <= m_data_wr[win_s*DW +: DW];
              cnt_r     <= '0;
              state_r   <= ST_BUSY;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (resp_s || tmo_s) begin
            s_cs      <= 1'b0;
            s_we      <= 1'b0;
            s_re      <= 1'b0;
            s_addr    <= '0;
            s_data_wr <= '0;
            state_r   <= ST_DONE;
            // A response on the timeout cycle still wins, so err only without it.
            m_err[grant_id] <= !resp_s;
            if (s_we) begin
              m_wack[grant_id] <= 1'b1;
            end else begin
              m_rdv[grant_id] <= 1'b1;
              m_data_rd       <= resp_s ? s_data_rd : ERR_DATA;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          s_cs    <= 1'b0;
          s_we    <= 1'b0;
          s_re    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cpu_arb.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_reg_cpu_arb
// Directed bench for reg_cpu_arb (4 masters, TIMEOUT_CYC = 8). The bench
// plays the slave itself, drives inputs 1 ns after each rising edge and
// checks registered outputs at the same point against hand-computed values.
// ---------------------------------------------------------------------------
module tb_reg_cpu_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    m_cs = '0;
  logic [N*AW-1:0] m_addr = '0;
  logic [N*DW-1:0] m_data_wr = '0;
  logic [N-1:0]    m_we = '0;
  logic [N-1:0]    m_re = '0;
  logic [DW-1:0]   m_data_rd;
  logic [N-1:0]    m_wack;
  logic [N-1:0]    m_rdv;
  logic [N-1:0]    m_err;
  logic            s_cs;
  logic            s_we;
  logic            s_re;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_data_wr;
  logic [DW-1:0]   s_data_rd = '0;
  logic            s_wack = 1'b0;
  logic            s_rdv = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;

  int checks = 0;
  int errors = 0;

  reg_cpu_arb #(
    .NUM_MST(N), .AW(AW), .DW(DW), .TIMEOUT_CYC(8), .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .reg_cpu_clk(clk), .rst_n(rst_n),
    .m_cs(m_cs), .m_addr(m_addr), .m_data_wr(m_data_wr),
    .m_we(m_we), .m_re(m_re),
    .m_data_rd(m_data_rd), .m_wack(m_wack), .m_rdv(m_rdv), .m_err(m_err),
    .s_cs(s_cs), .s_we(s_we), .s_re(s_re), .s_addr(s_addr),
    .s_data_wr(s_data_wr), .s_data_rd(s_data_rd),
    .s_wack(s_wack), .s_rdv(s_rdv),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] all_out();
    return {14'd0, s_cs, s_we, s_re, s_addr, s_data_wr, m_wack, m_rdv, m_err,
            m_data_rd, grant_id, busy};
  endfunction

  task automatic set_req(input int i, input logic we, input logic re,
                         input logic [31:0] a, input logic [31:0] d);
    m_cs[i] = 1'b1;
    m_we[i] = we;
    m_re[i] = re;
    m_addr[i*AW +: AW]    = a;
    m_data_wr[i*DW +: DW] = d;
  endtask

  task automatic drop_req(input int i);
    m_cs[i] = 1'b0;
    m_we[i] = 1'b0;
    m_re[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_cs = '0; m_we = '0; m_re = '0;
    s_wack = 1'b0; s_rdv = 1'b0;
    tick();
    tick();
    chk("reset_outputs", all_out(), 128'd0);
    rst_n = 1'b1;
  endtask

  // From IDLE with requests pending: expect master gid/addr granted, slave acks in 1 cycle.
  task automatic serve_write(input int gid, input logic [31:0] a);
    tick();
    chk($sformatf("rr_grant_%0d", gid), {126'd0, grant_id}, 128'(gid));
    chk($sformatf("rr_s_addr_%0d", gid), {96'd0, s_addr}, {96'd0, a});
    s_wack = 1'b1;
    tick();
    chk($sformatf("rr_wack_%0d", gid), {124'd0, m_wack}, 128'(1 << gid));
    s_wack = 1'b0;
    drop_req(gid);
    tick();
  endtask

  initial begin
    // ---- reset state ----
    do_reset();

    // ---- 1: m0 write, wrong-type s_rdv ignored, wack 3 cycles after s_cs ----
    set_req(0, 1'b1, 1'b0, 32'h10, 32'hA5);
    tick();
    chk("t1_s_cs", {127'd0, s_cs}, 128'd1);
    chk("t1_s_we_re", {126'd0, s_we, s_re}, 128'd2);
    chk("t1_s_addr", {96'd0, s_addr}, 128'h10);
    chk("t1_s_data_wr", {96'd0, s_data_wr}, 128'hA5);
    chk("t1_busy", {127'd0, busy}, 128'd1);
    s_rdv = 1'b1;
    tick();
    s_rdv = 1'b0;
    chk("t1_wrong_type_ignored", {123'd0, s_cs, m_rdv}, 128'h10);
    tick();
    s_wack = 1'b1;
    tick();
    chk("t1_s_cs_clear", {127'd0, s_cs}, 128'd0);
    chk("t1_m_wack", {124'd0, m_wack}, 128'd1);
    chk("t1_m_err", {124'd0, m_err}, 128'd0);
    s_wack = 1'b0;
    drop_req(0);
    tick();
    chk("t1_wack_once", {123'd0, m_wack, busy}, 128'd0);

    // ---- 2: round-robin order ----
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h100, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h101, 32'h1);
    set_req(2, 1'b1, 1'b0, 32'h102, 32'h2);
    serve_write(0, 32'h100);
    serve_write(1, 32'h101);
    serve_write(2, 32'h102);
    set_req(3, 1'b1, 1'b0, 32'h103, 32'h3);
    set_req(0, 1'b1, 1'b0, 32'h100, 32'h0);
    serve_write(3, 32'h103);
    serve_write(0, 32'h100);

    // ---- 3: m1 read timeout ----
    set_req(1, 1'b0, 1'b1, 32'h20, 32'h0);
    tick();
    chk("t3_grant", {126'd0, grant_id}, 128'd1);
    repeat (7) tick();
    chk("t3_s_cs_held", {127'd0, s_cs}, 128'd1);
    tick();
    chk("t3_s_cs_drop", {127'd0, s_cs}, 128'd0);
    chk("t3_m_rdv", {124'd0, m_rdv}, 128'h2);
    chk("t3_m_err", {124'd0, m_err}, 128'h2);
    chk("t3_data", {96'd0, m_data_rd}, 128'hDEADBEEF);
    drop_req(1);
    tick();
    chk("t3_data_clear", {96'd0, m_data_rd}, 128'd0);

    // ---- 4: illegal we&&re on m2 ----
    set_req(2, 1'b1, 1'b1, 32'h30, 32'h0);
    tick();
    chk("t4_s_cs", {127'd0, s_cs}, 128'd0);
    chk("t4_wack_err", {120'd0, m_wack, m_err}, 128'h44);
    chk("t4_grant_busy", {125'd0, grant_id, busy}, 128'd5);
    drop_req(2);
    tick();
    chk("t4_pulse_end", {124'd0, m_wack}, 128'd0);

    // ---- 5: s_rdv on the timeout cycle, then stray s_rdv ----
    set_req(0, 1'b0, 1'b1, 32'h40, 32'h0);
    tick();
    chk("t5_grant", {126'd0, grant_id}, 128'd0);
    repeat (7) tick();
    s_rdv = 1'b1;
    s_data_rd = 32'h1234;
    tick();
    chk("t5_m_rdv", {124'd0, m_rdv}, 128'd1);
    chk("t5_m_err", {124'd0, m_err}, 128'd0);
    chk("t5_data", {96'd0, m_data_rd}, 128'h1234);
    s_rdv = 1'b0;
    drop_req(0);
    tick();
    s_rdv = 1'b1;
    tick();
    s_rdv = 1'b0;
    chk("t5_stray_dropped", all_out(), 128'd0);

    // ---- 6: async reset while BUSY ----
    set_req(1, 1'b1, 1'b0, 32'h50, 32'h5);
    tick();
    chk("t6_busy_m1", {125'd0, grant_id, busy}, 128'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_clear", all_out(), 128'd0);
    set_req(0, 1'b1, 1'b0, 32'h60, 32'h6);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_m0_first", {126'd0, grant_id}, 128'd0);
    chk("t6_m0_addr", {96'd0, s_addr}, 128'h60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
